// File: rtl/adc_dac_pkg.sv
// Shared types and the signed-to-offset-binary mapping for the DAC return path.
// The mapping is the exact inverse of the ADC-side s = 2u - 255.
package adc_dac_pkg;

  localparam int SAMPLE_W = 9;
  localparam int CODE_W   = 8;
  localparam int OFFSET   = 255;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP_I = 3'd1,
    ST_WR_I    = 3'd2,
    ST_HOLD_I  = 3'd3,
    ST_SETUP_Q = 3'd4,
    ST_WR_Q    = 3'd5,
    ST_HOLD_Q  = 3'd6,
    ST_LOAD    = 3'd7
  } dac_state_e;

  typedef struct packed {
    logic [CODE_W-1:0] code_i;
    logic [CODE_W-1:0] code_q;
  } dac_pair_t;

  // Returns {clamped, code}; only s = -256 falls below zero and is clamped.
  function automatic logic [CODE_W:0] to_code(input logic signed [SAMPLE_W-1:0] s);
    logic signed [SAMPLE_W:0] t;
    t = $signed({s[SAMPLE_W-1], s}) + $signed(10'(OFFSET));
    if (t[SAMPLE_W]) begin
      return {1'b1, 8'h00};
    end else begin
      return {1'b0, t[SAMPLE_W-1:1]};
    end
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Single-clock show-ahead FIFO holding converted I/Q code pairs.
// Writes when full and reads when empty are ignored.
module sample_fifo
  import adc_dac_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_s;
  logic             pop_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == {CNT_W{1'b0}});
  assign push_s    = wr_en_i && !full_o;
  assign pop_s     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rptr_q];
  assign count_o   = count_q;

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= {AW{1'b0}};
      rptr_q  <= {AW{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      if (push_s) wptr_q <= wptr_q + AW'(1);
      if (pop_s)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // Storage array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
    end else if (push_s) begin
      mem_q[wptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/signed_to_dac.sv
// Converts signed 9-bit I/Q pairs to offset-binary codes and sequences them onto
// a shared-bus dual DAC: write I, write Q, then a common load strobe.
module signed_to_dac
  import adc_dac_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 1,
  parameter int WR_CYC     = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [SAMPLE_W-1:0] signal_in_real,
  input  logic signed [SAMPLE_W-1:0] signal_in_imag,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [CODE_W-1:0]          dac_data,
  output logic                       dac_sel,
  output logic                       dac_wr_n,
  output logic                       dac_ldac_n,
  output logic                       busy,
  output logic                       sat_flag,
  input  logic                       sat_clr
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] WR_LD    = 8'(WR_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

  dac_state_e        state_q, state_d;
  logic [7:0]        tmr_q, tmr_d;
  dac_pair_t         pair_q, pair_d;
  logic [CODE_W-1:0] data_q, data_d;
  logic              sel_q, sel_d;
  logic              wr_n_q, wr_n_d;
  logic              ldac_n_q, ldac_n_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              sat_q, sat_d;

  logic              push_s;
  logic              pop_s;
  logic              tmr_done_s;
  logic [CODE_W:0]   conv_i_s;
  logic [CODE_W:0]   conv_q_s;
  dac_pair_t         wr_pair_s;
  logic [15:0]       fifo_rd_s;
  dac_pair_t         head_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CNT_W-1:0]  fifo_cnt_s;
  logic [CNT_W-1:0]  fifo_cnt_nxt_s;

  assign push_s     = in_valid && ready_q;
  assign conv_i_s   = to_code(signal_in_real);
  assign conv_q_s   = to_code(signal_in_imag);
  assign wr_pair_s  = '{code_i: conv_i_s[CODE_W-1:0], code_q: conv_q_s[CODE_W-1:0]};
  assign head_s     = dac_pair_t'(fifo_rd_s);
  assign tmr_done_s = (tmr_q == 8'd0);

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (push_s),
    .wr_data_i (wr_pair_s),
    .rd_en_i   (pop_s),
    .rd_data_o (fifo_rd_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s),
    .count_o   (fifo_cnt_s)
  );

  // Sequencer: each phase loads the shared timer on entry and leaves when it hits zero.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    pair_d   = pair_q;
    data_d   = data_q;
    sel_d    = sel_q;
    wr_n_d   = 1'b1;
    ldac_n_d = 1'b1;
    pop_s    = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          pair_d  = head_s;
          data_d  = head_s.code_i;
          sel_d   = 1'b0;
          tmr_d   = SETUP_LD;
          state_d = ST_SETUP_I;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP_I, ST_SETUP_Q: begin
        if (tmr_done_s) begin
          wr_n_d  = 1'b0;
          tmr_d   = WR_LD;
          state_d = (state_q == ST_SETUP_I) ? ST_WR_I : ST_WR_Q;
        end else begin
          tmr_d   = tmr_q - 8'd1;
        end
      end
      ST_WR_I, ST_WR_Q: begin
        if (tmr_done_s) begin
          tmr_d   = HOLD_LD;
          state_d = (state_q == ST_WR_I) ? ST_HOLD_I : ST_HOLD_Q;
        end else begin
          wr_n_d  = 1'b0;
          tmr_d   = tmr_q - 8'd1;
        end
      end
      ST_HOLD_I: begin
        if (tmr_done_s) begin
          data_d  = pair_q.code_q;
          sel_d   = 1'b1;
          tmr_d   = SETUP_LD;
          state_d = ST_SETUP_Q;
        end else begin
          tmr_d   = tmr_q - 8'd1;
        end
      end
      ST_HOLD_Q: begin
        if (tmr_done_s) begin
          ldac_n_d = 1'b0;
          state_d  = ST_LOAD;
        end else begin
          tmr_d    = tmr_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next-cycle status flags; in_ready and busy track the occupancy after this edge.
  always_comb begin
    fifo_cnt_nxt_s = fifo_cnt_s + CNT_W'(push_s) - CNT_W'(pop_s);
    ready_d        = (fifo_cnt_nxt_s != CNT_W'(FIFO_DEPTH));
    busy_d         = (state_d != ST_IDLE) || (fifo_cnt_nxt_s != {CNT_W{1'b0}});
    if (push_s && (conv_i_s[CODE_W] || conv_q_s[CODE_W])) begin
      sat_d = 1'b1;
    end else if (sat_clr) begin
      sat_d = 1'b0;
    end else begin
      sat_d = sat_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      tmr_q    <= 8'd0;
      pair_q   <= '{code_i: 8'h00, code_q: 8'h00};
      data_q   <= 8'h00;
      sel_q    <= 1'b0;
      wr_n_q   <= 1'b1;
      ldac_n_q <= 1'b1;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      pair_q   <= pair_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
      wr_n_q   <= wr_n_d;
      ldac_n_q <= ldac_n_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      sat_q    <= sat_d;
    end
  end

  assign in_ready   = ready_q;
  assign dac_data   = data_q;
  assign dac_sel    = sel_q;
  assign dac_wr_n   = wr_n_q;
  assign dac_ldac_n = ldac_n_q;
  assign busy       = busy_q;
  assign sat_flag   = sat_q;

endmodule

// File: tb/tb_signed_to_dac.sv
// Scoreboard bench for signed_to_dac: stimulus queues expected code pairs, a
// negedge monitor checks every DAC write/load against them plus bus protocol.
module tb_signed_to_dac;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic signed [8:0] signal_in_real = 9'sd0;
  logic signed [8:0] signal_in_imag = 9'sd0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        dac_data;
  logic              dac_sel;
  logic              dac_wr_n;
  logic              dac_ldac_n;
  logic              busy;
  logic              sat_flag;
  logic              sat_clr = 1'b0;

  signed_to_dac dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .signal_in_real (signal_in_real),
    .signal_in_imag (signal_in_imag),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .dac_data       (dac_data),
    .dac_sel        (dac_sel),
    .dac_wr_n       (dac_wr_n),
    .dac_ldac_n     (dac_ldac_n),
    .busy           (busy),
    .sat_flag       (sat_flag),
    .sat_clr        (sat_clr)
  );

  always #5 clk = ~clk;

  typedef struct { int ci; int cq; } exp_t;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: ADC code u with s = 2u - 255, so u = floor((s + 255) / 2), clamped at 0.
  function automatic int model(input int s);
    if (s + 255 < 0) return 0;
    return (s + 255) / 2;
  endfunction

  // ---------------- monitor ----------------
  int   phase = 0;
  int   low_len = 0;
  int   cyc = 0;
  int   last_i_cyc = -1;
  bit   b2b_on = 1'b0;
  logic prev_wr = 1'b1;
  logic prev_ldac = 1'b1;
  logic [7:0] prev_data = 8'h00;
  logic prev_sel = 1'b0;
  time  last_ldac_edge = 0;
  time  last_iwr_edge = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      phase = 0; low_len = 0; prev_wr = 1'b1; prev_ldac = 1'b1; last_i_cyc = -1;
    end else begin
      cyc++;
      if (!b2b_on) last_i_cyc = -1;
      if (!dac_wr_n || !dac_ldac_n) chk("strobe_overlap", int'(!dac_wr_n && !dac_ldac_n), 0);
      if (!dac_wr_n && !prev_wr) begin
        chk("data_stable", dac_data, prev_data);
        chk("sel_stable", dac_sel, prev_sel);
        low_len++;
      end
      if (!dac_wr_n && prev_wr) begin
        low_len = 1;
        if (phase == 2) begin
          chk("write_before_load", phase, 0);
        end else if (exp_q.size() == 0) begin
          chk("write_without_pair", exp_q.size(), 1);
        end else if (phase == 0) begin
          chk("i_sel", dac_sel, 0);
          chk("i_code", dac_data, exp_q[0].ci);
          last_iwr_edge = $time - 5;
          if (b2b_on && last_i_cyc >= 0) chk("b2b_period", cyc - last_i_cyc, 9);
          last_i_cyc = cyc;
          phase = 1;
        end else begin
          chk("q_sel", dac_sel, 1);
          chk("q_code", dac_data, exp_q[0].cq);
          void'(exp_q.pop_front());
          phase = 2;
        end
      end
      if (dac_wr_n && !prev_wr) chk("wr_low_len", low_len, 2);
      if (!dac_ldac_n) begin
        chk("ldac_single", prev_ldac, 1);
        if (prev_ldac) begin
          chk("ldac_after_q", phase, 2);
          phase = 0;
          last_ldac_edge = $time - 5;
        end
      end
      prev_wr = dac_wr_n; prev_ldac = dac_ldac_n;
      prev_data = dac_data; prev_sel = dac_sel;
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input int si, input int sq, input int ei, input int eq,
                      output time t_acc, output bit stalled);
    int t = 0;
    signal_in_real = 9'(si);
    signal_in_imag = 9'(sq);
    in_valid = 1'b1;
    stalled = !in_ready;
    t_acc = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("push_timeout", in_ready, 1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back('{ei, eq});
      @(posedge clk);
      t_acc = $time;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_busy", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    time t_acc;
    bit  st;
    int  first_stall;
    int  t;

    repeat (3) @(negedge clk);
    chk("rst_data", dac_data, 0);
    chk("rst_sel", dac_sel, 0);
    chk("rst_wr_n", dac_wr_n, 1);
    chk("rst_ldac_n", dac_ldac_n, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat", sat_flag, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);

    // Directed first pair with latency checks.
    push(-255, 255, 0, 255, t_acc, st);
    chk("sat_clean", sat_flag, 0);
    @(negedge clk);
    chk("busy_running", busy, 1);
    chk("first_data", dac_data, 0);
    chk("first_sel", dac_sel, 0);
    t = 0;
    while (last_ldac_edge <= t_acc && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("ldac_latency", int'((last_ldac_edge - t_acc) / 10), 9);
    chk("wr_latency", int'((last_iwr_edge - t_acc) / 10), 2);
    drain();

    // Round-trip sweep over all ADC codes.
    for (int u = 0; u < 256; u++) push(2 * u - 255, 2 * u - 255, u, u, t_acc, st);
    drain();

    // Saturation: set, set-wins-over-clear, then clear.
    push(-256, 0, 0, 127, t_acc, st);
    chk("sat_set", sat_flag, 1);
    sat_clr = 1'b1;
    push(-256, 5, 0, 130, t_acc, st);
    sat_clr = 1'b0;
    chk("sat_set_wins", sat_flag, 1);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    chk("sat_cleared", sat_flag, 0);
    drain();

    // Burst: one leading pair then 6 with valid held; FIFO fills after 4.
    b2b_on = 1'b1;
    push(10, -10, model(10), model(-10), t_acc, st);
    @(negedge clk);
    first_stall = -1;
    for (int k = 0; k < 6; k++) begin
      int a = 37 * k - 200;
      int b = 180 - 61 * k;
      push(a, b, model(a), model(b), t_acc, st);
      if (st && first_stall < 0) first_stall = k;
    end
    chk("burst_accept_before_stall", first_stall, 4);
    drain();
    b2b_on = 1'b0;

    // Reset during the Q write strobe.
    push(100, -100, model(100), model(-100), t_acc, st);
    t = 0;
    while (!(dac_sel && !dac_wr_n) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("reached_wr_q", int'(dac_sel && !dac_wr_n), 1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_mid_wr_n", dac_wr_n, 1);
    chk("rst_mid_ldac_n", dac_ldac_n, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", in_ready, 1);
    push(-1, 1, 127, 128, t_acc, st);
    drain();

    // Randomized pairs with random gaps.
    for (int k = 0; k < 30; k++) begin
      int a = int'($urandom_range(511, 0)) - 256;
      int b = int'($urandom_range(511, 0)) - 256;
      push(a, b, model(a), model(b), t_acc, st);
      repeat ($urandom_range(12, 0)) @(negedge clk);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
